// File: rtl/project2.sv
// rtl/project2.sv - two-stage pipelined 16x32-bit processor with on-chip memories and memory-mapped board I/O
module project2_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] qc
);
  logic [31:0] regs [16];

  always_ff @(posedge clk) begin
    if (we) regs[waddr] <= wdata;
  end

  assign qa = regs[ra];
  assign qb = regs[rb];
  assign qc = regs[rc];
endmodule

module project2_mem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] data [WORDS];

  always_ff @(posedge clk) begin
    if (we) data[waddr] <= wdata;
  end

  assign rdata = data[raddr];
endmodule

module project2 #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 2048,
  parameter int TIMER_DIV  = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CLOCK_50,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic [9:0] LEDR,
  output logic [7:0] LEDG,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [3:0] OP_CMPR = 4'h2, OP_SW = 4'h3, OP_ALUI = 4'h4, OP_CMPI = 4'h6;
  localparam logic [3:0] OP_LW = 4'h7, OP_BCOND = 4'h8, OP_JAL = 4'hB, OP_ALUR = 4'hC;
  localparam logic [31:0] IO_KEY = 32'hF000_0000, IO_SW = 32'hF000_0004, IO_HEX = 32'hF000_0008;
  localparam logic [31:0] IO_LEDR = 32'hF000_000C, IO_LEDG = 32'hF000_0010, IO_TCNT = 32'hF000_0020;
  localparam logic [31:0] IO_TLIM = 32'hF000_0024, IO_TCTL = 32'hF000_0120;
  localparam logic [31:0] DIV_LAST = 32'(TIMER_DIV - 1);

  function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'h0:    alu = a + b;
      4'h1:    alu = a - b;
      4'h4:    alu = a & b;
      4'h5:    alu = a | b;
      4'h6:    alu = a ^ b;
      4'hC:    alu = ~(a & b);
      4'hD:    alu = ~(a | b);
      4'hE:    alu = ~(a ^ b);
      default: alu = '0;
    endcase
  endfunction

  function automatic logic cond(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic lt, eq;
    lt = $signed(a) < $signed(b);
    eq = (a == b);
    case (f)
      4'h1:    cond = eq;
      4'h2:    cond = lt;
      4'h3:    cond = lt | eq;
      4'h8:    cond = 1'b1;
      4'h9:    cond = !eq;
      4'hA:    cond = !lt;
      4'hB:    cond = !(lt | eq);
      default: cond = 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [31:0] pc, pc4, pc_next, instr, sx, boff;
  logic [3:0]  op, fn, rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] r1_raw, r2_raw, rdv_raw, r1, r2, rdv, alu_res, ex_res;
  logic        taken, is_cmp;

  logic [31:0] s2_alu, s2_sdata, s2_pc4;
  logic [3:0]  s2_op, s2_rd;
  logic        s2_memwrite, s2_memtoreg, s2_regwrite, s2_jal;
  logic [31:0] wb_val, mem_rdata, io_rdata, dmem_rdata;
  logic        s2_io;

  logic [15:0] hex;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [31:0] div, tcnt, tlim;
  logic        tctl_wrap, tctl_ovf, tick, wrap;

  assign {op, fn, rd, rs1, rs2} = instr[31:12];
  assign imm  = instr[15:0];
  assign sx   = {{16{imm[15]}}, imm};
  assign boff = {sx[29:0], 2'b00};
  assign pc4  = pc + 32'd4;

  project2_mem #(.WORDS(IMEM_WORDS)) instMemory (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0), .raddr(pc[IAW+1:2]), .rdata(instr)
  );

  project2_regfile dprf (
    .clk(clk), .we(s2_regwrite), .waddr(s2_rd), .wdata(wb_val),
    .ra(rs1), .rb(rs2), .rc(rd), .qa(r1_raw), .qb(r2_raw), .qc(rdv_raw)
  );

  // Stage-2 result (including load data) bypasses the regfile so dependent ops never wait
  assign r1  = (s2_regwrite && s2_rd == rs1) ? wb_val : r1_raw;
  assign r2  = (s2_regwrite && s2_rd == rs2) ? wb_val : r2_raw;
  assign rdv = (s2_regwrite && s2_rd == rd)  ? wb_val : rdv_raw;

  assign is_cmp  = (op == OP_CMPR) || (op == OP_CMPI);
  assign alu_res = (op == OP_ALUI && fn == 4'hB) ? {imm, 16'h0000}
                                                 : alu(fn, r1, (op == OP_ALUR) ? r2 : sx);
  assign ex_res  = is_cmp ? {31'b0, cond(fn, r1, (op == OP_CMPR) ? r2 : sx)}
                 : (op == OP_LW || op == OP_SW) ? r1 + sx : alu_res;
  assign taken   = (op == OP_BCOND) && cond(fn, rdv, r1);
  assign pc_next = taken ? pc4 + boff : (op == OP_JAL) ? r1 + boff : pc4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      s2_alu      <= '0;
      s2_sdata    <= '0;
      s2_pc4      <= '0;
      s2_op       <= '0;
      s2_rd       <= '0;
      s2_memwrite <= 1'b0;
      s2_memtoreg <= 1'b0;
      s2_regwrite <= 1'b0;
      s2_jal      <= 1'b0;
    end else begin
      pc          <= pc_next;
      s2_alu      <= ex_res;
      s2_sdata    <= rdv;
      s2_pc4      <= pc4;
      s2_op       <= op;
      s2_rd       <= rd;
      s2_memwrite <= (op == OP_SW);
      s2_memtoreg <= (op == OP_LW);
      s2_regwrite <= (op == OP_ALUR) || (op == OP_ALUI) || is_cmp || (op == OP_LW) || (op == OP_JAL);
      s2_jal      <= (op == OP_JAL);
    end
  end

  assign s2_io = (s2_alu[31:28] == 4'hF);

  project2_mem #(.WORDS(DMEM_WORDS)) dataMemory (
    .clk(clk), .we(s2_memwrite && !s2_io), .waddr(s2_alu[DAW+1:2]), .wdata(s2_sdata),
    .raddr(s2_alu[DAW+1:2]), .rdata(dmem_rdata)
  );

  always_comb begin
    io_rdata = '0;
    case (s2_alu)
      IO_KEY:  io_rdata = {28'b0, KEY};
      IO_SW:   io_rdata = {22'b0, SW};
      IO_HEX:  io_rdata = {16'b0, hex};
      IO_LEDR: io_rdata = {22'b0, ledr};
      IO_LEDG: io_rdata = {24'b0, ledg};
      IO_TCNT: io_rdata = tcnt;
      IO_TLIM: io_rdata = tlim;
      IO_TCTL: io_rdata = {29'b0, tctl_ovf, 1'b0, tctl_wrap};
      default: io_rdata = '0;
    endcase
  end

  assign mem_rdata = s2_io ? io_rdata : dmem_rdata;
  assign wb_val    = s2_memtoreg ? mem_rdata : s2_jal ? s2_pc4 : s2_alu;

  assign tick = (div == DIV_LAST);
  assign wrap = tick && (tlim != 0) && (tcnt == tlim - 1);

  // CPU writes come after the tick update so they win; wrap flags come last so a set is never lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex       <= '0;
      ledr      <= '0;
      ledg      <= '0;
      div       <= '0;
      tcnt      <= '0;
      tlim      <= '0;
      tctl_wrap <= 1'b0;
      tctl_ovf  <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 32'd1;
      if (tick) tcnt <= wrap ? '0 : tcnt + 32'd1;
      if (s2_memwrite && s2_io) begin
        case (s2_alu)
          IO_HEX:  hex  <= s2_sdata[15:0];
          IO_LEDR: ledr <= s2_sdata[9:0];
          IO_LEDG: ledg <= s2_sdata[7:0];
          IO_TCNT: tcnt <= s2_sdata;
          IO_TLIM: tlim <= s2_sdata;
          IO_TCTL: begin
            tctl_wrap <= tctl_wrap & s2_sdata[0];
            tctl_ovf  <= tctl_ovf & s2_sdata[2];
          end
          default: ;
        endcase
      end
      if (wrap) begin
        if (tctl_wrap) tctl_ovf <= 1'b1;
        else           tctl_wrap <= 1'b1;
      end
    end
  end

  assign LEDR = ledr;
  assign LEDG = ledg;
  assign HEX0 = seg7(hex[3:0]);
  assign HEX1 = seg7(hex[7:4]);
  assign HEX2 = seg7(hex[11:8]);
  assign HEX3 = seg7(hex[15:12]);

  logic unused_ok;
  assign unused_ok = ^{CLOCK_50, s2_op};
endmodule

// File: tb/tb_project2.sv
// tb/tb_project2.sv - self-checking bench for project2
module tb_project2;
  logic       clk = 1'b0;
  logic       reset;
  logic       CLOCK_50;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic [7:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  always #5 clk = ~clk;
  assign CLOCK_50 = clk;

  project2 #(.TIMER_DIV(4)) dut (
    .clk(clk), .reset(reset), .CLOCK_50(CLOCK_50), .SW(SW), .KEY(KEY),
    .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [21];

  logic [31:0] mr [16];
  logic [31:0] mm [16];
  logic [3:0]  alu_fns  [8] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hC, 4'hD, 4'hE};
  logic [3:0]  cond_fns [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [15:0] imm);
    return {op, fn, rd, rs1, imm};
  endfunction

  task automatic clear_state();
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.instMemory.data[i] = 32'h0;
    for (int i = 0; i < 16; i++)  dut.dprf.regs[i] = 32'h0;
    for (int i = 0; i < 128; i++) dut.dataMemory.data[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'hC: return ~(a & b);
      4'hD: return ~(a | b);
      4'hE: return ~(a ^ b);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      4'h1: return sa == sb;
      4'h2: return sa < sb;
      4'h3: return sa <= sb;
      4'h8: return 1'b1;
      4'h9: return sa != sb;
      4'hA: return sa >= sb;
      4'hB: return sa > sb;
      default: return 1'b0;
    endcase
  endfunction

  // Sequential ISA-level execution of one instruction against mr/mm
  task automatic ref_exec(input logic [31:0] i);
    logic [31:0] a, sx, ea;
    logic [3:0]  fn, rd;
    fn = i[27:24];
    rd = i[23:20];
    a  = mr[i[19:16]];
    sx = {{16{i[15]}}, i[15:0]};
    ea = a + sx;
    case (i[31:28])
      4'hC: mr[rd] = ref_alu(fn, a, mr[i[15:12]]);
      4'h4: mr[rd] = (fn == 4'hB) ? {i[15:0], 16'h0} : ref_alu(fn, a, sx);
      4'h2: mr[rd] = {31'b0, ref_cond(fn, a, mr[i[15:12]])};
      4'h6: mr[rd] = {31'b0, ref_cond(fn, a, sx)};
      4'h7: mr[rd] = mm[ea[5:2]];
      4'h3: mm[ea[5:2]] = mr[rd];
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] w;
    int kind;
    reset = 1'b0;
    SW    = '0;
    KEY   = '0;

    vt[0]  = '{4'hC, 4'h0, 32'd10,         32'd20,         16'h2000, 32'd30};
    vt[1]  = '{4'hC, 4'h1, 32'd5,          32'd7,          16'h2000, 32'hFFFF_FFFE};
    vt[2]  = '{4'hC, 4'h4, 32'hF0F0_F0F0,  32'hFF00_FF00,  16'h2000, 32'hF000_F000};
    vt[3]  = '{4'hC, 4'h5, 32'hF0F0_F0F0,  32'hFF00_FF00,  16'h2000, 32'hFFF0_FFF0};
    vt[4]  = '{4'hC, 4'h6, 32'hF0F0_F0F0,  32'hFF00_FF00,  16'h2000, 32'h0FF0_0FF0};
    vt[5]  = '{4'hC, 4'hC, 32'hF0F0_F0F0,  32'hFF00_FF00,  16'h2000, 32'h0FFF_0FFF};
    vt[6]  = '{4'hC, 4'hD, 32'hF0F0_F0F0,  32'hFF00_FF00,  16'h2000, 32'h000F_000F};
    vt[7]  = '{4'hC, 4'hE, 32'hF0F0_F0F0,  32'hFF00_FF00,  16'h2000, 32'hF00F_F00F};
    vt[8]  = '{4'hC, 4'h0, 32'hFFFF_FFFF,  32'd1,          16'h2000, 32'h0};
    vt[9]  = '{4'h4, 4'h0, 32'd100,        32'd0,          16'hFFFF, 32'd99};
    vt[10] = '{4'h4, 4'hB, 32'd5,          32'd0,          16'h1234, 32'h1234_0000};
    vt[11] = '{4'h2, 4'h2, 32'hFFFF_FFFF,  32'd1,          16'h2000, 32'd1};
    vt[12] = '{4'h2, 4'hB, 32'hFFFF_FFFF,  32'd1,          16'h2000, 32'd0};
    vt[13] = '{4'h2, 4'h3, 32'd5,          32'd5,          16'h2000, 32'd1};
    vt[14] = '{4'h2, 4'h9, 32'd5,          32'd5,          16'h2000, 32'd0};
    vt[15] = '{4'h2, 4'h8, 32'd3,          32'd9,          16'h2000, 32'd1};
    vt[16] = '{4'h2, 4'h0, 32'd3,          32'd3,          16'h2000, 32'd0};
    vt[17] = '{4'h6, 4'hA, 32'd0,          32'd0,          16'h8000, 32'd1};
    vt[18] = '{4'h6, 4'h1, 32'd7,          32'd0,          16'h0007, 32'd1};
    vt[19] = '{4'h0, 4'h0, 32'd1,          32'd2,          16'h2000, 32'hDEAD_BEEF};
    vt[20] = '{4'h4, 4'h1, 32'd10,         32'd0,          16'h0003, 32'd7};

    clear_state();
    chk("rst_pc",   dut.pc, 32'h0);
    chk("rst_ledr", {22'b0, LEDR}, 32'h0);
    chk("rst_ledg", {24'b0, LEDG}, 32'h0);
    chk("rst_hex0", {25'b0, HEX0}, 32'h40);
    chk("rst_hex3", {25'b0, HEX3}, 32'h40);

    for (int i = 0; i < 21; i++) begin
      clear_state();
      dut.dprf.regs[1] = vt[i].a;
      dut.dprf.regs[2] = vt[i].b;
      dut.dprf.regs[3] = 32'hDEAD_BEEF;
      dut.instMemory.data[0] = ins(vt[i].op, vt[i].fn, 4'd3, 4'd1, vt[i].imm);
      release_reset();
      step(2);
      chk($sformatf("vec%0d", i), dut.dprf.regs[3], vt[i].exp);
    end

    clear_state();
    dut.dprf.regs[1] = 32'd10;
    dut.dprf.regs[2] = 32'd20;
    dut.instMemory.data[0] = ins(4'hC, 4'h0, 4'd3, 4'd1, 16'h2000);
    dut.instMemory.data[1] = ins(4'hC, 4'h1, 4'd4, 4'd3, 16'h1000);
    release_reset();
    step(3);
    chk("fwd_r3", dut.dprf.regs[3], 32'd30);
    chk("fwd_r4", dut.dprf.regs[4], 32'd20);

    clear_state();
    dut.dprf.regs[2] = 32'd20;
    dut.instMemory.data[0] = ins(4'h3, 4'h0, 4'd2, 4'd0, 16'h0100);
    dut.instMemory.data[1] = ins(4'h7, 4'h0, 4'd5, 4'd0, 16'h0100);
    dut.instMemory.data[2] = ins(4'h4, 4'h0, 4'd6, 4'd5, 16'h0001);
    release_reset();
    step(4);
    chk("ldst_mem", dut.dataMemory.data[64], 32'd20);
    chk("ldst_r5",  dut.dprf.regs[5], 32'd20);
    chk("ldst_r6",  dut.dprf.regs[6], 32'd21);

    clear_state();
    dut.dprf.regs[1] = 32'd5;
    dut.instMemory.data[0] = ins(4'h8, 4'h1, 4'd1, 4'd1, 16'h0002);
    dut.instMemory.data[1] = ins(4'h4, 4'h0, 4'd7, 4'd0, 16'h0001);
    dut.instMemory.data[2] = ins(4'h4, 4'h0, 4'd7, 4'd0, 16'h0002);
    dut.instMemory.data[3] = ins(4'hB, 4'h0, 4'd15, 4'd0, 16'h0008);
    dut.instMemory.data[4] = ins(4'h4, 4'h0, 4'd8, 4'd0, 16'h0005);
    dut.instMemory.data[8] = ins(4'h8, 4'h2, 4'd1, 4'd1, 16'h0002);
    dut.instMemory.data[9] = ins(4'h4, 4'h0, 4'd9, 4'd0, 16'h0009);
    release_reset();
    step(1);
    chk("br_pc", dut.pc, 32'h0C);
    step(1);
    chk("jal_pc", dut.pc, 32'h20);
    step(3);
    chk("br_skip_r7", dut.dprf.regs[7], 32'h0);
    chk("jal_skip_r8", dut.dprf.regs[8], 32'h0);
    chk("jal_r15", dut.dprf.regs[15], 32'h10);
    chk("br_nt_r9", dut.dprf.regs[9], 32'd9);

    clear_state();
    SW  = 10'h2A5;
    KEY = 4'hA;
    dut.dprf.regs[6] = 32'hFFFF_FFFF;
    dut.instMemory.data[0] = ins(4'h4, 4'hB, 4'd1, 4'd0, 16'hF000);
    dut.instMemory.data[1] = ins(4'h7, 4'h0, 4'd2, 4'd1, 16'h0004);
    dut.instMemory.data[2] = ins(4'h4, 4'h0, 4'd3, 4'd0, 16'h03FF);
    dut.instMemory.data[3] = ins(4'h3, 4'h0, 4'd3, 4'd1, 16'h000C);
    dut.instMemory.data[4] = ins(4'h4, 4'h0, 4'd4, 4'd0, 16'h1234);
    dut.instMemory.data[5] = ins(4'h3, 4'h0, 4'd4, 4'd1, 16'h0008);
    dut.instMemory.data[6] = ins(4'h4, 4'h0, 4'd5, 4'd0, 16'h00A5);
    dut.instMemory.data[7] = ins(4'h3, 4'h0, 4'd5, 4'd1, 16'h0010);
    dut.instMemory.data[8] = ins(4'h7, 4'h0, 4'd6, 4'd1, 16'h0030);
    dut.instMemory.data[9] = ins(4'h7, 4'h0, 4'd7, 4'd1, 16'h0000);
    release_reset();
    step(4);
    chk("ledr_before", {22'b0, LEDR}, 32'h0);
    step(1);
    chk("ledr_commit", {22'b0, LEDR}, 32'h3FF);
    step(8);
    chk("io_sw",    dut.dprf.regs[2], 32'h2A5);
    chk("io_key",   dut.dprf.regs[7], 32'hA);
    chk("io_unmap", dut.dprf.regs[6], 32'h0);
    chk("io_ledg",  {24'b0, LEDG}, 32'hA5);
    chk("hex0", {25'b0, HEX0}, 32'h19);
    chk("hex1", {25'b0, HEX1}, 32'h30);
    chk("hex2", {25'b0, HEX2}, 32'h24);
    chk("hex3", {25'b0, HEX3}, 32'h79);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_pc",   dut.pc, 32'h0);
    chk("mid_rst_ledr", {22'b0, LEDR}, 32'h0);
    chk("mid_rst_ledg", {24'b0, LEDG}, 32'h0);
    chk("mid_rst_hex0", {25'b0, HEX0}, 32'h40);
    SW  = '0;
    KEY = '0;

    clear_state();
    dut.instMemory.data[0]  = ins(4'h4, 4'hB, 4'd1, 4'd0, 16'hF000);
    dut.instMemory.data[1]  = ins(4'h4, 4'h0, 4'd2, 4'd0, 16'h0003);
    dut.instMemory.data[2]  = ins(4'h3, 4'h0, 4'd2, 4'd1, 16'h0024);
    dut.instMemory.data[3]  = ins(4'h4, 4'h0, 4'd3, 4'd0, 16'h0007);
    dut.instMemory.data[4]  = ins(4'h4, 4'h0, 4'd4, 4'd0, 16'h0005);
    dut.instMemory.data[26] = ins(4'h3, 4'h0, 4'd3, 4'd1, 16'h0020);
    dut.instMemory.data[27] = ins(4'h3, 4'h0, 4'd0, 4'd1, 16'h0120);
    dut.instMemory.data[28] = ins(4'h3, 4'h0, 4'd4, 4'd1, 16'h0120);
    release_reset();
    step(11);
    chk("tmr11_wrap", {31'b0, dut.tctl_wrap}, 32'h0);
    chk("tmr11_cnt",  dut.tcnt, 32'd2);
    step(1);
    chk("tmr12_wrap", {31'b0, dut.tctl_wrap}, 32'h1);
    chk("tmr12_cnt",  dut.tcnt, 32'd0);
    step(11);
    chk("tmr23_ovf", {31'b0, dut.tctl_ovf}, 32'h0);
    step(1);
    chk("tmr24_ovf",  {31'b0, dut.tctl_ovf}, 32'h1);
    chk("tmr24_wrap", {31'b0, dut.tctl_wrap}, 32'h1);
    step(4);
    chk("tcnt_cpu_wins", dut.tcnt, 32'd7);
    step(1);
    chk("tctl_clr_wrap", {31'b0, dut.tctl_wrap}, 32'h0);
    chk("tctl_clr_ovf",  {31'b0, dut.tctl_ovf}, 32'h0);
    step(1);
    chk("tctl_noset", {29'b0, dut.tctl_ovf, 1'b0, dut.tctl_wrap}, 32'h0);

    for (int round = 0; round < 4; round++) begin
      clear_state();
      for (int r = 0; r < 16; r++) mr[r] = (r >= 1 && r <= 7) ? $urandom : 32'h0;
      for (int k = 0; k < 16; k++) mm[k] = $urandom;
      for (int r = 0; r < 16; r++) dut.dprf.regs[r] = mr[r];
      for (int k = 0; k < 16; k++) dut.dataMemory.data[k] = mm[k];
      for (int k = 0; k < 32; k++) begin
        kind = $urandom_range(0, 5);
        w = $urandom;
        w[23:20] = 4'($urandom_range(1, 7));
        w[19:16] = 4'($urandom_range(0, 7));
        w[15]    = (kind == 0 || kind == 2) ? 1'b0 : w[15];
        case (kind)
          0: w[31:24] = {4'hC, alu_fns[$urandom_range(0, 7)]};
          1: w[31:24] = {4'h4, ($urandom_range(0, 8) == 8) ? 4'hB : alu_fns[$urandom_range(0, 7)]};
          2: w[31:24] = {4'h2, cond_fns[$urandom_range(0, 7)]};
          3: w[31:24] = {4'h6, cond_fns[$urandom_range(0, 7)]};
          default: begin
            w[31:24] = (kind == 4) ? 8'h70 : 8'h30;
            w[19:16] = 4'h0;
            w[15:0]  = {10'b0, 4'($urandom_range(0, 15)), 2'b00};
          end
        endcase
        dut.instMemory.data[k] = w;
        ref_exec(w);
      end
      release_reset();
      step(34);
      for (int r = 0; r < 16; r++)
        chk($sformatf("rnd%0d_r%0d", round, r), dut.dprf.regs[r], mr[r]);
      for (int k = 0; k < 16; k++)
        chk($sformatf("rnd%0d_m%0d", round, k), dut.dataMemory.data[k], mm[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
